// File: rtl/trigger_gen_if.sv
// Signal bundle between trigger_gen and its environment (arming, sample words,
// downstream saver handshake, trigger and status outputs).
interface trigger_gen_if;
  logic        enable_i;
  logic [15:0] ch_i;
  logic        event_saved_i;
  logic        full_i;
  logic        trigger_o;
  logic [3:0]  trig_pos_o;
  logic        busy_o;
  logic [31:0] trig_count_o;
  logic [15:0] lost_count_o;
  logic        err_timeout_o;

  modport master (
    output enable_i, ch_i, event_saved_i, full_i,
    input  trigger_o, trig_pos_o, busy_o, trig_count_o, lost_count_o, err_timeout_o
  );

  modport slave (
    input  enable_i, ch_i, event_saved_i, full_i,
    output trigger_o, trig_pos_o, busy_o, trig_count_o, lost_count_o, err_timeout_o
  );
endinterface

// File: rtl/trigger_gen.sv
// Pulse-width qualified trigger generator: finds the first run of MIN_WIDTH ones in each
// 16-sample word, fires a fixed-length trigger, waits for the saver, then holds off.
module trigger_gen #(
  parameter int unsigned MIN_WIDTH    = 3,
  parameter int unsigned TRIG_LEN     = 4,
  parameter int unsigned HOLDOFF      = 16,
  parameter int unsigned SAVE_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         aresetn,
  trigger_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFire, StWaitSave, StHoldoff} state_e;

  localparam logic [4:0]  MinW     = 5'(MIN_WIDTH);
  localparam logic [15:0] TrigLast = 16'(TRIG_LEN - 1);
  localparam logic [15:0] SaveLast = 16'(SAVE_TIMEOUT - 1);
  // HOLDOFF of 0 still spends one cycle in the holdoff state.
  localparam logic [15:0] HoldLast = 16'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  run_q, run_d;
  logic        trigger_q, trigger_d;
  logic [3:0]  pos_q, pos_d;
  logic [31:0] trig_cnt_q, trig_cnt_d;
  logic [15:0] lost_q, lost_d;
  logic        err_q, err_d;
  logic        hit;
  logic [3:0]  hit_pos;

  // Walk the word oldest-first; the run count carries across word boundaries.
  always_comb begin
    run_d   = run_q;
    hit     = 1'b0;
    hit_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (bus.ch_i[i]) begin
        if (run_d != 5'd31) run_d = run_d + 5'd1;
        if (!hit && run_d == MinW) begin
          hit     = 1'b1;
          hit_pos = 4'(i);
        end
      end else begin
        run_d = '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    trigger_d  = trigger_q;
    pos_d      = pos_q;
    trig_cnt_d = trig_cnt_q;
    lost_d     = lost_q;
    err_d      = err_q;

    if (hit && bus.enable_i && (state_q != StIdle || bus.full_i) && lost_q != 16'hFFFF) begin
      lost_d = lost_q + 16'd1;
    end

    if (!bus.enable_i) begin
      state_d   = StIdle;
      trigger_d = 1'b0;
      err_d     = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (hit && !bus.full_i) begin
            state_d    = StFire;
            trigger_d  = 1'b1;
            cnt_d      = '0;
            pos_d      = hit_pos;
            trig_cnt_d = trig_cnt_q + 32'd1;
          end
        end
        StFire: begin
          if (cnt_q == TrigLast) begin
            state_d   = StWaitSave;
            trigger_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StWaitSave: begin
          if (bus.event_saved_i) begin
            state_d = StHoldoff;
            cnt_d   = '0;
          end else if (cnt_q == SaveLast) begin
            state_d = StHoldoff;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StHoldoff: begin
          if (cnt_q == HoldLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      run_q      <= 5'd31;
      trigger_q  <= 1'b0;
      pos_q      <= '0;
      trig_cnt_q <= '0;
      lost_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      trigger_q  <= trigger_d;
      pos_q      <= pos_d;
      trig_cnt_q <= trig_cnt_d;
      lost_q     <= lost_d;
      err_q      <= err_d;
    end
  end

  assign bus.trigger_o     = trigger_q;
  assign bus.trig_pos_o    = pos_q;
  assign bus.busy_o        = (state_q != StIdle);
  assign bus.trig_count_o  = trig_cnt_q;
  assign bus.lost_count_o  = lost_q;
  assign bus.err_timeout_o = err_q;

endmodule
